// File: rtl/led_sequencer_if.sv
// ============================================================================
// Module      : led_sequencer_if
// Description : Control and pattern-output bundle for led_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       mode;
    logic             dir;
    logic             pause;
    logic [WIDTH-1:0] leds;
    logic             tick;

    modport master (output mode, output dir, output pause, input leds, input tick);
    modport slave  (input mode, input dir, input pause, output leds, output tick);
endinterface

`default_nettype wire

// File: rtl/led_sequencer.sv
// ============================================================================
// Module      : led_sequencer
// Description : Prescaled LED pattern generator (binary, gray, rotate, bounce).
//               Optional macro LED_SEQ_INPUT_SYNC_EN adds 2-flop input syncs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_sequencer #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 100
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    led_sequencer_if.slave   bus
);
    localparam int PW   = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    localparam int POSW = $clog2(WIDTH);

    localparam logic [PW-1:0]   c_PRESC_LAST = PW'(MAX_COUNT - 1);
    localparam logic [POSW-1:0] c_POS_LAST   = POSW'(WIDTH - 1);

    localparam logic [1:0] c_MODE_BIN    = 2'b00;
    localparam logic [1:0] c_MODE_GRAY   = 2'b01;
    localparam logic [1:0] c_MODE_ONEHOT = 2'b10;
    localparam logic [1:0] c_MODE_BOUNCE = 2'b11;

    logic [1:0]       w_mode;
    logic             w_dir;
    logic             w_pause;

`ifdef LED_SEQ_INPUT_SYNC_EN
    logic [1:0] r_mode_s1, r_mode_s2;
    logic       r_dir_s1,  r_dir_s2;
    logic       r_pause_s1, r_pause_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_s1  <= 2'b00;
            r_mode_s2  <= 2'b00;
            r_dir_s1   <= 1'b0;
            r_dir_s2   <= 1'b0;
            r_pause_s1 <= 1'b0;
            r_pause_s2 <= 1'b0;
        end else begin
            r_mode_s1  <= bus.mode;
            r_mode_s2  <= r_mode_s1;
            r_dir_s1   <= bus.dir;
            r_dir_s2   <= r_dir_s1;
            r_pause_s1 <= bus.pause;
            r_pause_s2 <= r_pause_s1;
        end
    end

    assign w_mode  = r_mode_s2;
    assign w_dir   = r_dir_s2;
    assign w_pause = r_pause_s2;
`else
    assign w_mode  = bus.mode;
    assign w_dir   = bus.dir;
    assign w_pause = bus.pause;
`endif

    logic [PW-1:0]    r_presc, w_presc_nxt;
    logic [WIDTH-1:0] r_cnt,   w_cnt_nxt;
    logic [POSW-1:0]  r_pos,   w_pos_nxt;
    logic             r_bdir,  w_bdir_nxt;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_leds,  w_leds_nxt;
    logic             r_tick,  w_tick_nxt;
    logic             w_mode_chg;
    logic             w_wrap;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_cnt   <= '0;
            r_pos   <= '0;
            r_bdir  <= 1'b1;
            r_mode  <= c_MODE_BIN;
            r_leds  <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pos   <= w_pos_nxt;
            r_bdir  <= w_bdir_nxt;
            r_mode  <= w_mode;
            r_leds  <= w_leds_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // Next-state: a mode change clears everything and outranks both pause and wrap
    always_comb begin
        w_presc_nxt = r_presc;
        w_cnt_nxt   = r_cnt;
        w_pos_nxt   = r_pos;
        w_bdir_nxt  = r_bdir;
        w_tick_nxt  = 1'b0;
        w_mode_chg  = (w_mode != r_mode);
        w_wrap      = (r_presc == c_PRESC_LAST);

        if (w_mode_chg) begin
            w_presc_nxt = '0;
            w_cnt_nxt   = '0;
            w_pos_nxt   = '0;
            w_bdir_nxt  = 1'b1;
        end else if (!w_pause) begin
            if (w_wrap) begin
                w_presc_nxt = '0;
                w_tick_nxt  = 1'b1;
                case (r_mode)
                    c_MODE_BIN, c_MODE_GRAY: begin
                        w_cnt_nxt = w_dir ? (r_cnt + 1'b1) : (r_cnt - 1'b1);
                    end
                    c_MODE_ONEHOT: begin
                        if (w_dir)
                            w_pos_nxt = (r_pos == c_POS_LAST) ? '0 : (r_pos + 1'b1);
                        else
                            w_pos_nxt = (r_pos == '0) ? c_POS_LAST : (r_pos - 1'b1);
                    end
                    default: begin
                        if (r_bdir && (r_pos == c_POS_LAST)) begin
                            w_pos_nxt  = r_pos - 1'b1;
                            w_bdir_nxt = 1'b0;
                        end else if (!r_bdir && (r_pos == '0)) begin
                            w_pos_nxt  = POSW'(1);
                            w_bdir_nxt = 1'b1;
                        end else begin
                            w_pos_nxt  = r_bdir ? (r_pos + 1'b1) : (r_pos - 1'b1);
                        end
                    end
                endcase
            end else begin
                w_presc_nxt = r_presc + 1'b1;
            end
        end
    end

    // Output: pattern of the next state, so held states reproduce the current leds
    always_comb begin
        w_leds_nxt = '0;
        case (w_mode)
            c_MODE_BIN:    w_leds_nxt = w_cnt_nxt;
            c_MODE_GRAY:   w_leds_nxt = w_cnt_nxt ^ (w_cnt_nxt >> 1);
            c_MODE_ONEHOT,
            c_MODE_BOUNCE: w_leds_nxt = WIDTH'(1) << w_pos_nxt;
            default:       w_leds_nxt = '0;
        endcase
    end

    assign bus.leds = r_leds;
    assign bus.tick = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_led_sequencer.sv
// ============================================================================
// Module      : tb_led_sequencer
// Description : Randomized self-checking bench for led_sequencer (W=8, MC=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_sequencer;
    localparam int W  = 8;
    localparam int MC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    led_sequencer_if #(.WIDTH(W)) bus ();

    led_sequencer #(.WIDTH(W), .MAX_COUNT(MC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: prescaler count, counter value, rotate position, bounce phase
    int       m_presc, m_cnt, m_pos, m_phase;
    logic [1:0] m_mode;
    bit       m_tick;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Bounce walks a triangle of period 2W-2: 0,1,..,W-1,W-2,..,1
    function automatic logic [W-1:0] exp_leds();
        int p;
        case (m_mode)
            2'd0:    return W'(m_cnt);
            2'd1:    return W'(m_cnt ^ (m_cnt >> 1));
            2'd2:    return W'(1 << m_pos);
            default: begin
                p = (m_phase < W) ? m_phase : (2 * W - 2 - m_phase);
                return W'(1 << p);
            end
        endcase
    endfunction

    task automatic model_reset();
        m_presc = 0; m_cnt = 0; m_pos = 0; m_phase = 0; m_mode = 2'd0; m_tick = 0;
    endtask

    task automatic model_edge();
        m_tick = 0;
        if (bus.mode != m_mode) begin
            m_mode = bus.mode; m_presc = 0; m_cnt = 0; m_pos = 0; m_phase = 0;
        end else if (!bus.pause) begin
            if (m_presc == MC - 1) begin
                m_presc = 0;
                m_tick  = 1;
                case (m_mode)
                    2'd0, 2'd1: m_cnt   = (m_cnt + (bus.dir ? 1 : (1 << W) - 1)) % (1 << W);
                    2'd2:       m_pos   = (m_pos + (bus.dir ? 1 : W - 1)) % W;
                    default:    m_phase = (m_phase + 1) % (2 * W - 2);
                endcase
            end else begin
                m_presc++;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        chk("leds", {24'd0, bus.leds}, {24'd0, exp_leds()});
        chk("tick", {31'd0, bus.tick}, {31'd0, m_tick});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Called 1 time unit after an edge: reset lands strictly between edges
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_leds", {24'd0, bus.leds}, 32'd0);
        chk("rst_tick", {31'd0, bus.tick}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_presc(input int target);
        for (int i = 0; i < 4 * MC && m_presc != target; i++) cycle();
        chk("presc_reach", m_presc, target);
    endtask

    initial begin
        bus.mode  = 2'd0;
        bus.dir   = 1'b1;
        bus.pause = 1'b0;
        model_reset();
        #2;
        chk("init_leds", {24'd0, bus.leds}, 32'd0);
        chk("init_tick", {31'd0, bus.tick}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Binary up through full wrap
        run(MC * 256 + 2 * MC);

        // Binary down from reset
        async_reset();
        bus.dir = 1'b0;
        run(MC * 5);

        // Gray up
        bus.mode = 2'd1; bus.dir = 1'b1;
        run(MC * 10);

        // Bounce with dir toggling
        bus.mode = 2'd3;
        for (int i = 0; i < MC * 30; i++) begin
            bus.dir = 1'($urandom);
            cycle();
        end

        // Pause mid-count, then mode change mid-count
        bus.mode = 2'd0; bus.dir = 1'b1;
        cycle();
        run_until_presc(2);
        bus.pause = 1'b1;
        run(10);
        bus.pause = 1'b0;
        run(MC + 1);
        bus.mode = 2'd2;
        run(MC * 3);

        // Mode change on a wrap cycle, and together with pause
        run_until_presc(MC - 1);
        bus.mode = 2'd3;
        cycle();
        bus.pause = 1'b1; bus.mode = 2'd1;
        run(3);
        bus.pause = 1'b0;
        run(MC * 2);

        // Async reset mid-sequence with a non-binary mode held
        bus.mode = 2'd2;
        run(MC * 2 + 1);
        async_reset();
        run(MC * 3);

        // Randomized soak
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 79) == 0) bus.mode  = 2'($urandom);
            if ($urandom_range(0, 29) == 0) bus.dir   = ~bus.dir;
            if ($urandom_range(0, 19) == 0) bus.pause = ~bus.pause;
            cycle();
            if ($urandom_range(0, 999) == 0) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
